// File: rtl/ahb_mux_master_pipe.sv
// AHB master-side multiplexer with a one-stage address/data pipeline.
// The address/control payload is steered combinationally by the arbiter's
// one-hot grant. The write data is steered by a registered copy of that
// grant, which advances only on HREADY.
module ahb_mux_master_pipe #(
  parameter int CHANNEL_NUM = 4,
  parameter int ADDR_PL     = 46,
  parameter int DATA_W      = 32,
  parameter int HTRANS_LSB  = 32
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [CHANNEL_NUM-1:0][ADDR_PL-1:0] addr_pl_in,
  input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  wdata_in,
  input  logic [CHANNEL_NUM-1:0]              sel,
  input  logic                                hready,
  output logic [ADDR_PL-1:0]                  addr_pl_out,
  output logic [DATA_W-1:0]                   wdata_out,
  output logic [CHANNEL_NUM-1:0]              data_sel,
  output logic                                data_active,
  output logic                                sel_err
);

  logic                   w_any;
  logic                   w_multi;
  logic                   w_onehot;
  logic [ADDR_PL-1:0]     w_addr;
  logic [DATA_W-1:0]      w_wdata;
  logic [CHANNEL_NUM-1:0] r_data_sel;
  logic                   r_data_active;
  logic                   r_sel_err;

  // Clearing the lowest set bit leaves something only if two or more bits are set.
  assign w_any    = |sel;
  assign w_multi  = |(sel & (sel - CHANNEL_NUM'(1)));
  assign w_onehot = w_any & ~w_multi;

  // Address phase mux: an illegal or absent grant presents IDLE (all-zero).
  always_comb begin
    w_addr = '0;
    if (w_onehot) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        if (sel[i]) w_addr = addr_pl_in[i];
      end
    end
  end

  // Data phase mux: steered by the registered owner, zero when nobody owns it.
  always_comb begin
    w_wdata = '0;
    for (int j = 0; j < CHANNEL_NUM; j++) begin
      if (r_data_sel[j]) w_wdata = wdata_in[j];
    end
  end

  // Pipeline the grant into the data phase; wait states freeze the owner.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_data_sel    <= '0;
      r_data_active <= 1'b0;
    end else if (hready) begin
      r_data_sel    <= w_onehot ? sel : '0;
      r_data_active <= w_onehot & w_addr[HTRANS_LSB+1];
    end
  end

  // Sticky record of any multi-hot grant, cleared only by reset.
  always_ff @(posedge HCLK) begin
    if (HRESET)       r_sel_err <= 1'b0;
    else if (w_multi) r_sel_err <= 1'b1;
  end

  assign addr_pl_out = w_addr;
  assign wdata_out   = w_wdata;
  assign data_sel    = r_data_sel;
  assign data_active = r_data_active;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_ahb_mux_master_pipe.sv
// Testbench for ahb_mux_master_pipe: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_ahb_mux_master_pipe;
  localparam int N  = 4;
  localparam int AW = 46;
  localparam int DW = 32;
  localparam int HT = 32;

  logic                     HCLK = 1'b0;
  logic                     HRESET;
  logic [N-1:0][AW-1:0]     addr_pl_in;
  logic [N-1:0][DW-1:0]     wdata_in;
  logic [N-1:0]             sel;
  logic                     hready;
  logic [AW-1:0]            addr_pl_out;
  logic [DW-1:0]            wdata_out;
  logic [N-1:0]             data_sel;
  logic                     data_active;
  logic                     sel_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who owns the data phase, whether it is a real transfer, error seen.
  logic [N-1:0] m_owner;
  logic         m_active;
  logic         m_err;

  ahb_mux_master_pipe #(.CHANNEL_NUM(N), .ADDR_PL(AW), .DATA_W(DW), .HTRANS_LSB(HT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .addr_pl_in(addr_pl_in), .wdata_in(wdata_in),
    .sel(sel), .hready(hready), .addr_pl_out(addr_pl_out), .wdata_out(wdata_out),
    .data_sel(data_sel), .data_active(data_active), .sel_err(sel_err)
  );

  always #5 HCLK = ~HCLK;

  function automatic int ones(input logic [N-1:0] s);
    int c = 0;
    for (int k = 0; k < N; k++) c += int'(s[k]);
    return c;
  endfunction

  function automatic int first_idx(input logic [N-1:0] s);
    for (int k = 0; k < N; k++) if (s[k]) return k;
    return 0;
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    if (ones(sel) == 1) return addr_pl_in[first_idx(sel)];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_wdata();
    if (m_owner == '0) return '0;
    return wdata_in[first_idx(m_owner)];
  endfunction

  task automatic randomize_payloads();
    for (int k = 0; k < N; k++) begin
      addr_pl_in[k] = {$urandom, $urandom};
      wdata_in[k]   = $urandom;
    end
  endtask

  task automatic set_htrans(input int ch, input logic [1:0] t);
    addr_pl_in[ch][HT+1 -: 2] = t;
  endtask

  // Advance one clock, apply the transfer rules to the model, settle past the edge.
  task automatic tick();
    logic [N-1:0] s;
    logic         nonseq;
    s = sel;
    nonseq = (ones(s) == 1) && addr_pl_in[first_idx(s)][HT+1];
    @(posedge HCLK);
    if (HRESET) begin
      m_owner = '0; m_active = 1'b0; m_err = 1'b0;
    end else begin
      if (ones(s) > 1) m_err = 1'b1;
      if (hready) begin
        m_owner  = (ones(s) == 1) ? s : '0;
        m_active = nonseq;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; hready = 1'b1; sel = 4'b0000;
    randomize_payloads();
    tick(); tick();
    n_tests++; if (data_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_data_sel got %b want 0000", data_sel); end
    n_tests++; if (data_active !== 1'b0) begin n_fail++; $display("FAIL reset_data_active got %b want 0", data_active); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    n_tests++; if (wdata_out !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", wdata_out); end
    HRESET = 1'b0;
  endtask

  task automatic test_single();
    randomize_payloads();
    set_htrans(1, 2'b10);
    sel = 4'b0010; hready = 1'b1;
    #1;
    n_tests++; if (addr_pl_out !== addr_pl_in[1]) begin n_fail++; $display("FAIL single_addr got %h want %h", addr_pl_out, addr_pl_in[1]); end
    tick();
    sel = 4'b0000;
    #1;
    n_tests++; if (data_sel !== 4'b0010) begin n_fail++; $display("FAIL single_data_sel got %b want 0010", data_sel); end
    n_tests++; if (data_active !== 1'b1) begin n_fail++; $display("FAIL single_active got %b want 1", data_active); end
    n_tests++; if (wdata_out !== wdata_in[1]) begin n_fail++; $display("FAIL single_wdata got %h want %h", wdata_out, wdata_in[1]); end
    n_tests++; if (addr_pl_out !== '0) begin n_fail++; $display("FAIL single_idle_addr got %h want 0", addr_pl_out); end
    tick();
  endtask

  task automatic test_wait_states();
    randomize_payloads();
    set_htrans(0, 2'b10); set_htrans(2, 2'b11);
    sel = 4'b0001; hready = 1'b1;
    tick();
    sel = 4'b0100; hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (data_sel !== 4'b0001) begin n_fail++; $display("FAIL wait_hold_%0d got %b want 0001", c, data_sel); end
      n_tests++; if (wdata_out !== wdata_in[0]) begin n_fail++; $display("FAIL wait_wdata_%0d got %h want %h", c, wdata_out, wdata_in[0]); end
    end
    hready = 1'b1;
    tick();
    n_tests++; if (data_sel !== 4'b0100) begin n_fail++; $display("FAIL wait_release got %b want 0100", data_sel); end
    n_tests++; if (data_active !== 1'b1) begin n_fail++; $display("FAIL wait_active got %b want 1", data_active); end
    sel = 4'b0000; tick();
  endtask

  task automatic test_back_to_back();
    randomize_payloads();
    set_htrans(0, 2'b10); set_htrans(3, 2'b10);
    sel = 4'b0001; hready = 1'b1;
    tick();
    sel = 4'b1000;
    #1;
    n_tests++; if (addr_pl_out !== addr_pl_in[3]) begin n_fail++; $display("FAIL b2b_addr got %h want %h", addr_pl_out, addr_pl_in[3]); end
    n_tests++; if (wdata_out !== wdata_in[0]) begin n_fail++; $display("FAIL b2b_old_wdata got %h want %h", wdata_out, wdata_in[0]); end
    tick();
    n_tests++; if (wdata_out !== wdata_in[3]) begin n_fail++; $display("FAIL b2b_new_wdata got %h want %h", wdata_out, wdata_in[3]); end
    n_tests++; if (data_sel !== 4'b1000) begin n_fail++; $display("FAIL b2b_data_sel got %b want 1000", data_sel); end
    sel = 4'b0000; tick();
  endtask

  task automatic test_idle();
    randomize_payloads();
    set_htrans(2, 2'b00);
    sel = 4'b0100; hready = 1'b1;
    tick();
    n_tests++; if (data_sel !== 4'b0100) begin n_fail++; $display("FAIL idle_data_sel got %b want 0100", data_sel); end
    n_tests++; if (data_active !== 1'b0) begin n_fail++; $display("FAIL idle_active got %b want 0", data_active); end
    sel = 4'b0000; tick();
  endtask

  task automatic test_illegal();
    randomize_payloads();
    set_htrans(1, 2'b10); set_htrans(2, 2'b10);
    sel = 4'b0110; hready = 1'b1;
    #1;
    n_tests++; if (addr_pl_out !== '0) begin n_fail++; $display("FAIL illegal_addr got %h want 0", addr_pl_out); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_early got %b want 0", sel_err); end
    tick();
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", sel_err); end
    n_tests++; if (data_sel !== 4'b0000) begin n_fail++; $display("FAIL illegal_data_sel got %b want 0000", data_sel); end
    n_tests++; if (data_active !== 1'b0) begin n_fail++; $display("FAIL illegal_active got %b want 0", data_active); end
    sel = 4'b0001;
    tick(); tick();
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b want 1", sel_err); end
  endtask

  task automatic test_reset_mid();
    randomize_payloads();
    set_htrans(1, 2'b11);
    sel = 4'b0010; hready = 1'b1;
    tick();
    n_tests++; if (data_sel !== 4'b0010) begin n_fail++; $display("FAIL rmid_setup got %b want 0010", data_sel); end
    HRESET = 1'b1; hready = 1'b0;
    tick();
    n_tests++; if (data_sel !== 4'b0000) begin n_fail++; $display("FAIL rmid_data_sel got %b want 0000", data_sel); end
    n_tests++; if (data_active !== 1'b0) begin n_fail++; $display("FAIL rmid_active got %b want 0", data_active); end
    n_tests++; if (wdata_out !== '0) begin n_fail++; $display("FAIL rmid_wdata got %h want 0", wdata_out); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b want 0", sel_err); end
    n_tests++; if (addr_pl_out !== addr_pl_in[1]) begin n_fail++; $display("FAIL rmid_addr got %h want %h", addr_pl_out, addr_pl_in[1]); end
    HRESET = 1'b0; hready = 1'b1;
    tick();
    n_tests++; if (data_sel !== 4'b0010) begin n_fail++; $display("FAIL rmid_first_edge got %b want 0010", data_sel); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      randomize_payloads();
      case ($urandom_range(0, 9))
        0:       sel = 4'b0000;
        1:       sel = 4'($urandom);
        default: sel = 4'(1 << $urandom_range(0, N-1));
      endcase
      hready = ($urandom_range(0, 3) != 0);
      HRESET = ($urandom_range(0, 49) == 0);
      #1;
      n_tests++;
      if (addr_pl_out !== exp_addr()) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_addr cyc %0d sel %b got %h want %h", c, sel, addr_pl_out, exp_addr());
      end
      tick();
      n_tests++;
      if ({data_sel, data_active, sel_err, wdata_out} !== {m_owner, m_active, m_err, exp_wdata()}) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_state cyc %0d got sel=%b act=%b err=%b wd=%h want sel=%b act=%b err=%b wd=%h",
                   c, data_sel, data_active, sel_err, wdata_out, m_owner, m_active, m_err, exp_wdata());
      end
    end
    HRESET = 1'b0;
  endtask

  initial begin
    m_owner = '0; m_active = 1'b0; m_err = 1'b0;
    test_reset();
    test_single();
    test_wait_states();
    test_back_to_back();
    test_idle();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mux_master_pipe.md
AHB_MUX_MASTER_PIPE -- requirements
Module: ahb_mux_master_pipe

Interface
REQ-001 Parameter CHANNEL_NUM, default 4: number of master channels, legal range 1..16.
REQ-002 Parameter ADDR_PL, default 46: address/control payload width (HADDR 32, HTRANS 2, HWRITE, HSIZE 3, HBURST 3, HPROT 4, HMASTLOCK).
REQ-003 Parameter DATA_W, default 32: HWDATA width.
REQ-004 Parameter HTRANS_LSB, default 32: bit offset of HTRANS[1:0] inside the address payload.
REQ-005 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-006 HRESET  in  1  synchronous, active-high reset.
REQ-007 addr_pl_in  in  CHANNEL_NUM x ADDR_PL  per-master address/control payload.
REQ-008 wdata_in  in  CHANNEL_NUM x DATA_W  per-master write data.
REQ-009 sel  in  CHANNEL_NUM  one-hot address-phase grant from arbiter.
REQ-010 hready  in  1  HREADY returned from the slave side.
REQ-011 addr_pl_out  out  ADDR_PL  muxed address/control payload.
REQ-012 wdata_out  out  DATA_W  muxed write data, steered by data-phase owner.
REQ-013 data_sel  out  CHANNEL_NUM  registered one-hot data-phase owner.
REQ-014 data_active  out  1  a NONSEQ/SEQ transfer is in its data phase.
REQ-015 sel_err  out  1  sticky flag: sel was observed non-one-hot and non-zero.

Function
REQ-016 addr_pl_out SHALL equal addr_pl_in[i] combinationally when sel has exactly bit i set.
REQ-017 addr_pl_out SHALL be all-zero (HTRANS = IDLE) when sel is zero or has more than one bit set.
REQ-018 On a rising edge with hready=1, data_sel SHALL load sel if sel is one-hot, else all-zero.
REQ-019 On a rising edge with hready=0, data_sel and data_active SHALL hold their values, regardless of sel.
REQ-020 On a rising edge with hready=1, data_active SHALL load 1 iff sel is one-hot and addr_pl_out[HTRANS_LSB+1]=1 (NONSEQ/SEQ), else 0.
REQ-021 wdata_out SHALL equal wdata_in[j] combinationally when data_sel has bit j set, and all-zero when data_sel is zero.
REQ-022 Address-to-data latency SHALL be exactly one hready=1 edge; wait states extend the data phase without limit.
REQ-023 sel_err SHALL set on any edge where sel has two or more bits set, and clear only on reset.
REQ-024 Back-to-back grants to different masters SHALL be pipelined: the new master's address phase overlaps the old master's data phase with no bubble.
REQ-025 With CHANNEL_NUM=1, the block SHALL behave identically with sel treated as a 1-bit grant.
REQ-026 The implementation SHALL use no latches, and all outputs SHALL be free of X when inputs are known.

Reset
REQ-027 While HRESET=1 at a rising edge: data_sel<=0, data_active<=0, sel_err<=0, taking priority over hready and sel.
REQ-028 Reset asserted mid data phase SHALL force wdata_out to zero from the following cycle; addr_pl_out stays combinational on sel.
REQ-029 After HRESET deasserts, the first hready=1 edge SHALL behave per REQ-018/REQ-020 with no extra delay.

Verification
REQ-030 Single transfer: sel=0010, HTRANS=NONSEQ, hready=1, one edge -> data_sel=0010, data_active=1, wdata_out=wdata_in[1].
REQ-031 Wait states: sel=0001 captured, then hready=0 for 3 cycles while sel=0100 -> data_sel stays 0001 for all 3 cycles, then becomes 0100 on the next hready=1 edge.
REQ-032 Master switch: sel 0001->1000 on consecutive hready=1 edges -> addr_pl_out switches to master 3 in the same cycle that wdata_out still shows master 0.
REQ-033 Illegal grant: sel=0110 -> addr_pl_out=0; next edge -> sel_err=1 and data_sel=0; sel_err stays 1 after sel returns to one-hot.
REQ-034 IDLE transfer: sel=0100, HTRANS=00, hready=1 -> data_sel=0100, data_active=0.
REQ-035 Reset mid-burst: HRESET=1 during a data phase with data_sel=0010 -> next cycle data_sel=0, data_active=0, wdata_out=0, sel_err=0.
